// File: rtl/cpld_spi_pkg.sv
// Shared types and constants for the MCU-side SPI master that talks to the CPLD core logic.
// Opcode values mirror the CPLD MCU state encoding.
package cpld_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_FETCH = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } spi_state_e;

  localparam logic [7:0] MCU_OPCODE        = 8'h00;
  localparam logic [7:0] MCU_READ_STATUS   = 8'h01;
  localparam logic [7:0] MCU_WRITE_COMMAND = 8'h02;
  localparam logic [7:0] MCU_ACCESS_RAM    = 8'h03;
  localparam logic [7:0] MCU_RESET         = 8'h04;

  typedef enum logic [1:0] {
    RPC_NONE    = 2'd0,
    RPC_ISSUED  = 2'd1,
    RPC_WAITING = 2'd2
  } rpc_cmd_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cpld_host_spi_master_phase_timer.sv
// Loadable down-counter; o_tick is high on the last cycle of a loaded phase.
// Loading N-1 therefore gives a phase exactly N cycles long.
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_tick
);

  logic [W-1:0] r_count;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != {W{1'b0}}) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tick = (r_count == {W{1'b0}});

endmodule

// File: rtl/cpld_host_spi_master.sv
// Mode-0, LSB-first SPI master: one opcode byte plus 0..255 streamed data bytes per nSS frame,
// driving the CPLD MCU port. All SPI pins are registered; reset raises nSS immediately.
module cpld_host_spi_master
  import cpld_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SETUP_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic [7:0] length,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       spi_nss,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int TW = $clog2(max3(CLK_DIV, SETUP_CYC, GAP_CYC) + 1);
  localparam logic [TW-1:0] LD_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_HALF  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LD_GAP   = TW'(GAP_CYC - 1);
  // The FETCH cycle doubles as the first low cycle of the next byte; with CLK_DIV=1
  // one extra low cycle is kept so MOSI is never updated on the rising edge.
  localparam logic [TW-1:0] LD_FETCH = TW'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);

  spi_state_e  r_state;
  logic [7:0]  r_tx_shift, r_rx_shift, r_rx_data, r_bytes_left;
  logic [2:0]  r_bit_cnt;
  logic        r_is_opcode, r_abort;
  logic        r_nss, r_sck, r_mosi, r_tx_ready, r_rx_valid, r_busy, r_done;
  logic        w_tick, w_load, w_start_ok, w_more, w_xfer;
  logic [TW-1:0] w_load_val;
  logic [7:0]  w_rx_byte;

  assign w_start_ok = start & ~r_done;
  assign w_more     = (r_bytes_left != 8'd0) & ~r_abort & ~abort;
  assign w_xfer     = tx_valid & r_tx_ready;
  assign w_rx_byte  = {spi_miso, r_rx_shift[7:1]};

  spi_phase_timer #(.W(TW)) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_tick  (w_tick)
  );

  // Phase-length reload on every state change that enters a timed phase.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = LD_HALF;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_load     = 1'b1;
          w_load_val = LD_SETUP;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_SETUP, ST_LOW: begin
        w_load = w_tick;
      end
      ST_HIGH: begin
        if (w_tick && (r_bit_cnt != 3'd7)) begin
          w_load = 1'b1;
        end else if (w_tick && !w_more) begin
          w_load     = 1'b1;
          w_load_val = LD_SETUP;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_FETCH: begin
        if (w_xfer) begin
          w_load     = 1'b1;
          w_load_val = LD_FETCH;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_load     = 1'b1;
          w_load_val = LD_GAP;
        end else begin
          w_load = 1'b0;
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Frame sequencer with registered SPI pins and stream handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tx_shift   <= 8'h00;
      r_rx_shift   <= 8'h00;
      r_rx_data    <= 8'h00;
      r_bytes_left <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_is_opcode  <= 1'b0;
      r_abort      <= 1'b0;
      r_nss        <= 1'b1;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      if (abort && r_busy) begin
        r_abort <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_tx_shift   <= opcode;
            r_mosi       <= opcode[0];
            r_bytes_left <= length;
            r_bit_cnt    <= 3'd0;
            r_is_opcode  <= 1'b1;
            r_abort      <= 1'b0;
            r_busy       <= 1'b1;
            r_nss        <= 1'b0;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_LOW;
        end
        ST_LOW: begin
          if (w_tick) begin
            r_sck   <= 1'b1;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            r_sck      <= 1'b0;
            r_rx_shift <= w_rx_byte;
            if (r_bit_cnt != 3'd7) begin
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_mosi     <= r_tx_shift[1];
              r_state    <= ST_LOW;
            end else begin
              r_bit_cnt   <= 3'd0;
              r_is_opcode <= 1'b0;
              if (!r_is_opcode) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
              end
              if (w_more) begin
                r_tx_ready <= 1'b1;
                r_state    <= ST_FETCH;
              end else begin
                r_state <= ST_HOLD;
              end
            end
          end
        end
        ST_FETCH: begin
          if (w_xfer) begin
            r_tx_shift   <= tx_data;
            r_mosi       <= tx_data[0];
            r_bytes_left <= r_bytes_left - 8'd1;
            r_tx_ready   <= 1'b0;
            r_state      <= ST_LOW;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_nss   <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_nss  = r_nss;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_cpld_host_spi_master.sv
// Bench for cpld_host_spi_master: a CPLD slave model feeds MISO and a scoreboard checks
// MOSI bytes and RX pulses against expectations queued when each frame is launched.
module tb_cpld_host_spi_master;

  localparam int CLK_DIV   = 2;
  localparam int SETUP_CYC = 4;
  localparam int GAP_CYC   = 4;

  logic       clk = 1'b0;
  logic       reset, start, tx_valid, tx_ready, rx_valid, abort, busy, done;
  logic       spi_nss, spi_sck, spi_mosi, spi_miso;
  logic [7:0] opcode, length, tx_data, rx_data;

  always #5 clk = ~clk;

  cpld_host_spi_master #(
    .CLK_DIV(CLK_DIV), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .length(length),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .abort(abort), .busy(busy), .done(done),
    .spi_nss(spi_nss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mosi_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] miso_bytes[8];

  int cyc = 0, rises = 0, nss_low = 0, rx_cnt = 0, done_cnt = 0, ready_cnt = 0, frames = 0;
  int rise_cyc = 0, done_cyc = 0;
  int b_rises, b_nss_low, b_rx, b_done, b_ready, b_frames;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // CPLD slave model and output scoreboard, sampling on the falling clk edge.
  task automatic monitor_loop();
    logic       prev_nss = 1'b1;
    logic       prev_sck = 1'b0;
    logic [7:0] macc = 8'h00;
    logic [7:0] exp_b;
    int         mbits = 0;
    int         sbyte = 0;
    int         sbit = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        mbits = 0;
      end else begin
        if (prev_nss && !spi_nss) begin
          frames++;
          mbits = 0;
          sbyte = 0;
          sbit  = 0;
          spi_miso = miso_bytes[0][0];
        end
        if (!prev_nss && spi_nss) rise_cyc = cyc;
        if (!spi_nss) nss_low++;
        if (!prev_sck && spi_sck) begin
          rises++;
          macc = {spi_mosi, macc[7:1]};
          mbits++;
          if (mbits == 8) begin
            mbits = 0;
            check_eq("mosi_q_avail", 32'(mosi_q.size() != 0), 32'd1);
            if (mosi_q.size() != 0) begin
              exp_b = mosi_q.pop_front();
              check_eq("mosi_byte", 32'(macc), 32'(exp_b));
            end
          end
        end
        if (prev_sck && !spi_sck && !spi_nss) begin
          sbit++;
          if (sbit == 8) begin
            sbit = 0;
            if (sbyte < 7) sbyte++;
          end
          spi_miso = miso_bytes[sbyte][sbit];
        end
        if (rx_valid) begin
          rx_cnt++;
          check_eq("rx_q_avail", 32'(rx_q.size() != 0), 32'd1);
          if (rx_q.size() != 0) begin
            exp_b = rx_q.pop_front();
            check_eq("rx_byte", 32'(rx_data), 32'(exp_b));
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (tx_ready) ready_cnt++;
      end
      prev_nss = spi_nss;
      prev_sck = spi_sck;
    end
  endtask

  task automatic snap();
    b_rises = rises; b_nss_low = nss_low; b_rx = rx_cnt;
    b_done = done_cnt; b_ready = ready_cnt; b_frames = frames;
  endtask

  task automatic start_frame(input logic [7:0] opc, input logic [7:0] len);
    mosi_q.push_back(opc);
    opcode = opc;
    length = len;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic serve_byte(input logic [7:0] b, input int stall);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      tick();
      n++;
    end
    check_eq("tx_ready_seen", 32'(tx_ready), 32'd1);
    if (tx_ready) begin
      mosi_q.push_back(b);
      for (int i = 0; i < stall; i++) begin
        check_eq("stall_ready", 32'(tx_ready), 32'd1);
        check_eq("stall_sck", 32'(spi_sck), 32'd0);
        tick();
      end
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string pfx);
    int n = 0;
    while (done_cnt == b_done && n < 3000) begin
      tick();
      n++;
    end
    check_eq({pfx, "_done_seen"}, 32'(done_cnt != b_done), 32'd1);
    check_eq({pfx, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string pfx, input int e_rises, input int e_rx, input int e_ready);
    check_eq({pfx, "_sck_rises"}, 32'(rises - b_rises), 32'(e_rises));
    check_eq({pfx, "_rx_pulses"}, 32'(rx_cnt - b_rx), 32'(e_rx));
    check_eq({pfx, "_ready_cyc"}, 32'(ready_cnt - b_ready), 32'(e_ready));
    check_eq({pfx, "_done_pulses"}, 32'(done_cnt - b_done), 32'd1);
    check_eq({pfx, "_frames"}, 32'(frames - b_frames), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; opcode = 8'h00; length = 8'h00;
    tx_data = 8'h00; tx_valid = 1'b0; abort = 1'b0; spi_miso = 1'b0;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
    fork
      monitor_loop();
    join_none
    repeat (3) tick();
    check_eq("rst_nss", 32'(spi_nss), 32'd1);
    check_eq("rst_sck", 32'(spi_sck), 32'd0);
    check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Opcode 0x03 + one data byte 0xA5, slave returns 0x3C.
    miso_bytes[0] = 8'h00; miso_bytes[1] = 8'h3C;
    snap();
    start_frame(8'h03, 8'd1);
    rx_q.push_back(8'h3C);
    serve_byte(8'hA5, 0);
    wait_done("t1");
    repeat (5) tick();
    check_frame("t1", 16, 1, 1);
    check_eq("t1_nss_low", 32'(nss_low - b_nss_low), 32'(SETUP_CYC + 16 * 2 * CLK_DIV + SETUP_CYC));

    // Opcode only: status poll with zero data bytes.
    miso_bytes[0] = 8'h5A;
    snap();
    start_frame(8'h01, 8'd0);
    wait_done("t2");
    repeat (5) tick();
    check_frame("t2", 8, 0, 0);
    check_eq("t2_nss_low", 32'(nss_low - b_nss_low), 32'(SETUP_CYC + 8 * 2 * CLK_DIV + SETUP_CYC));
    check_eq("t2_gap_to_done", 32'(done_cyc - rise_cyc), 32'(GAP_CYC));

    // Status read: data byte returns 0x5A.
    miso_bytes[0] = 8'h00; miso_bytes[1] = 8'h5A;
    snap();
    start_frame(8'h01, 8'd1);
    rx_q.push_back(8'h5A);
    serve_byte(8'h00, 0);
    wait_done("t3");
    repeat (5) tick();
    check_frame("t3", 16, 1, 1);
    check_eq("t3_rx_data", 32'(rx_data), 32'h5A);

    // TX stall of 10 cycles before the first data byte.
    miso_bytes[1] = 8'hC3; miso_bytes[2] = 8'h7E;
    snap();
    start_frame(8'h03, 8'd2);
    rx_q.push_back(8'hC3);
    rx_q.push_back(8'h7E);
    serve_byte(8'h11, 10);
    serve_byte(8'h22, 0);
    wait_done("t4");
    repeat (5) tick();
    check_frame("t4", 24, 2, 12);

    // Reset while SCK is high on the fifth bit of the data byte.
    miso_bytes[1] = 8'h99;
    snap();
    start_frame(8'h04, 8'd1);
    serve_byte(8'h3C, 0);
    n = 0;
    while ((rises - b_rises) < 13 && n < 2000) begin
      tick();
      n++;
    end
    check_eq("t5_rise13_seen", 32'(rises - b_rises), 32'd13);
    check_eq("t5_sck_before", 32'(spi_sck), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t5_nss_on_reset", 32'(spi_nss), 32'd1);
    check_eq("t5_sck_on_reset", 32'(spi_sck), 32'd0);
    check_eq("t5_busy_on_reset", 32'(busy), 32'd0);
    check_eq("t5_ready_on_reset", 32'(tx_ready), 32'd0);
    check_eq("t5_rxdata_on_reset", 32'(rx_data), 32'd0);
    tick();
    reset = 1'b0;
    mosi_q.delete();
    rx_q.delete();
    repeat (3) tick();
    miso_bytes[1] = 8'h42;
    snap();
    start_frame(8'h02, 8'd1);
    rx_q.push_back(8'h42);
    serve_byte(8'h81, 0);
    wait_done("t5");
    repeat (5) tick();
    check_frame("t5", 16, 1, 1);

    // Abort during the first of four data bytes, plus a start while busy.
    miso_bytes[1] = 8'h96;
    snap();
    start_frame(8'h03, 8'd4);
    rx_q.push_back(8'h96);
    serve_byte(8'hE7, 0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    opcode = 8'h02;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done("t6");
    repeat (30) tick();
    check_frame("t6", 16, 1, 1);
    check_eq("t6_busy_idle", 32'(busy), 32'd0);

    check_eq("mosi_q_drained", 32'(mosi_q.size()), 32'd0);
    check_eq("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpld_host_spi_master.md
Name: cpld_host_spi_master

Overview:
- Synchronous SPI master on the MCU side that drives the CPLD core-logic MCU port (mcu_nss/mcu_sck/mcu_mosi/mcu_miso).
- Sends one opcode byte, then 0..255 data bytes in one nSS frame.
- Data bytes flow in from a valid/ready TX stream; each received byte is presented as a one-cycle RX pulse.
- Used for command writes, status polls and shared serial-RAM access through the CPLD.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period (legal ≥1).
- SETUP_CYC, 4, clk cycles from nSS low to first SCK rise, and from last SCK fall to nSS high.
- GAP_CYC, 4, minimum clk cycles nSS stays high between frames.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a frame; ignored while busy
- opcode  in  8  opcode byte; captured on accepted start
- length  in  8  number of data bytes after opcode; captured on accepted start
- tx_data  in  8  next data byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted this cycle (tx_valid & tx_ready = transfer)
- rx_data  out  8  last received data byte
- rx_valid  out  1  one-cycle pulse, rx_data updated
- abort  in  1  end frame at next byte boundary
- busy  out  1  high from accepted start until the GAP phase ends
- done  out  1  one-cycle pulse at the end of the GAP phase
- spi_nss  out  1  to mcu_nss, active-low
- spi_sck  out  1  to mcu_sck, idle low
- spi_mosi  out  1  to mcu_mosi
- spi_miso  in  1  from mcu_miso; treated as synchronous to clk (SCK derived from clk)

Behaviour:
- Reset values: spi_nss=1, spi_sck=0, spi_mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, state=IDLE.
- Reset mid-frame aborts immediately; nSS rises combinatorially via the async reset (the CPLD resets its frame on nSS rise).
- SPI mode 0. Every byte goes LSB first, opcode included.
- MOSI changes only while SCK is low: at the start of the low phase.
- MISO is sampled on the last clk cycle of each SCK high phase, immediately before the falling edge.
- States and transitions:
  - IDLE: start → latch opcode/length, shift register ← opcode, busy=1, go to SETUP.
  - SETUP: nss=0, sck=0, mosi=bit0; hold SETUP_CYC cycles, then go to LOW.
  - LOW: sck=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: sck=1 for CLK_DIV cycles; sample MISO in the last cycle; SCK falls.
    - bit<7: shift, mosi=next bit, go to LOW.
    - bit==7, data byte: rx_valid pulse with the assembled byte.
    - bit==7, opcode byte: RX byte discarded, no rx_valid.
    - bit==7: go to FETCH if bytes_left>0 and !abort, else go to HOLD.
  - FETCH: sck=0, tx_ready=1 until tx_valid. On transfer: shift ← tx_data, mosi=bit0, bytes_left−1, go to LOW. SCK held low indefinitely while stalled (no SCK edges).
  - HOLD: nss=0, sck=0 for SETUP_CYC cycles, then go to GAP.
  - GAP: nss=1 for GAP_CYC cycles; done pulse on the last cycle, then go to IDLE with busy=0.
- length=0: opcode byte only, 8 SCK pulses.
- abort is latched when asserted and acted on at the next byte boundary; the current byte always completes.
- start while busy: ignored, not queued. start and done in the same cycle: start ignored.
- Counters:
  - half-period counter: $clog2(max(CLK_DIV,SETUP_CYC,GAP_CYC)+1) bits.
  - bit counter: 3 bits.
  - bytes_left: 8 bits, never wraps below 0.

Decomposition:
- Package cpld_spi_pkg holds:
  - the state enum;
  - opcode constants matching the CPLD MCU state encoding: OPCODE, READ_STATUS, WRITE_COMMAND, ACCESS_RAM, RESET;
  - RPC command constants NONE/ISSUED/WAITING.
- One sub-module: spi_phase_timer, a loadable down-counter giving a terminal-count tick; shared by SETUP/LOW/HIGH/HOLD/GAP.

Test Plan:
- CLK_DIV=2, opcode 0x03, length 1, tx 0xA5; CPLD model echoing MOSI → 16 SCK rises, MOSI LSB-first 11000000 10100101. nSS low exactly 4+16·4+4 = 72 cycles. rx_valid once; done once.
- length 0, opcode 0x01; model returns status 0x5A as cop_status[bit] → exactly 8 SCK pulses, no rx_valid, done after GAP_CYC.
- Status read: opcode 0x01, length 1, model drives 0x5A on data byte → rx_data=0x5A with a single rx_valid pulse.
- TX stall: length 2, tx_valid low 10 cycles in FETCH → spi_sck constant 0, tx_ready high all 10 cycles, frame resumes with no extra SCK edge; total SCK rises 24.
- reset asserted after SCK rise 5 of a data byte → spi_nss=1 and spi_sck=0 in the same cycle; busy=0; next start runs a clean frame.
- abort during byte 1 of length 4 → byte 1 completes (rx_valid once), no tx_ready after it, HOLD then GAP, done pulse; start during busy produces no second frame.
